// File: rtl/spart_echo_driver.sv
// spart_echo_driver
// Host-side driver for a SPART. After reset it writes the 16-bit baud
// divisor selected by br_cfg (low byte to DB low, high byte to DB high),
// then echoes every received byte back out. Received bytes go through an
// internal FIFO and are sent only while the SPART reports tbr. A change on
// br_cfg while idle rewrites the divisor without a reset and keeps the FIFO.
//
// Optional feature macro: DRV_CRLF_EN
//   defined   - after a received 0x0D, a 0x0A is also queued (CR -> CR LF)
//   undefined - bytes are echoed verbatim
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   br_cfg       baud select: 00=4800, 01=9600, 10=19200, 11=38400
//   iocs         SPART chip select, high only during a bus access cycle
//   iorw         1 = read, 0 = write
//   rda          SPART receive data available
//   tbr          SPART transmit buffer ready
//   ioaddr       00=data, 01=status, 10=DB low, 11=DB high
//   databus      bidirectional data, driven only on write cycles
//   cfg_done     high once a divisor write pair has completed
//   fifo_count   current FIFO occupancy
//   overflow     sticky, set when an RX byte was dropped on a full FIFO
//   clr_overflow synchronous clear of overflow (a simultaneous set wins)
module spart_echo_driver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH  = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    br_cfg,
  output logic          iocs,
  output logic          iorw,
  input  logic          rda,
  input  logic          tbr,
  output logic [1:0]    ioaddr,
  inout  wire  [7:0]    databus,
  output logic          cfg_done,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    RST_WAIT,
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_READ,
    RX_SETTLE,
    TX_WRITE,
    TX_SETTLE
  } state_t;

  state_t          state, state_next;
  logic [1:0]      br_q;
  logic [15:0]     divisor;
  logic [7:0]      drive_data;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push_req, do_push, drop, do_pop;
  logic [7:0]      push_data;
  logic            crlf_push;

  function automatic logic [15:0] divisor_for(input logic [1:0] sel);
    int baud;
    case (sel)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    return 16'(CLK_FREQ_HZ / baud);
  endfunction

  assign divisor    = divisor_for(br_q);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_WAIT;
    else      state <= state_next;
  end

  // IDLE priority: reconfigure, then receive, then transmit.
  always_comb begin
    state_next = state;
    case (state)
      RST_WAIT:  state_next = CFG_LO;
      CFG_LO:    state_next = CFG_HI;
      CFG_HI:    state_next = IDLE;
      IDLE: begin
        if (br_cfg != br_q)                state_next = CFG_LO;
        else if (rda)                      state_next = RX_READ;
        else if (tbr && (count != '0))     state_next = TX_WRITE;
      end
      RX_READ:   state_next = RX_SETTLE;
      RX_SETTLE: state_next = IDLE;
      TX_WRITE:  state_next = TX_SETTLE;
      TX_SETTLE: state_next = IDLE;
      default:   state_next = RST_WAIT;
    endcase
  end

  always_comb begin
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = 2'b00;
    drive_data = 8'h00;
    case (state)
      CFG_LO: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = 2'b10;
        drive_data = divisor[7:0];
      end
      CFG_HI: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = 2'b11;
        drive_data = divisor[15:8];
      end
      RX_READ: begin
        iocs = 1'b1;
      end
      TX_WRITE: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        drive_data = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  assign databus = (iocs && !iorw) ? drive_data : 8'hzz;

`ifdef DRV_CRLF_EN
  // Remembers whether the byte just read was a CR so RX_SETTLE can add LF.
  logic rx_cr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rx_cr <= 1'b0;
    else if (state == RX_READ) rx_cr <= (databus == 8'h0D);
  end

  assign crlf_push = (state == RX_SETTLE) && rx_cr;
`else
  assign crlf_push = 1'b0;
`endif

  assign push_req  = (state == RX_READ) || crlf_push;
  assign push_data = (state == RX_READ) ? databus : 8'h0A;
  assign do_push   = push_req && !full;
  assign drop      = push_req && full;
  assign do_pop    = (state == TX_WRITE);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  // br_q follows br_cfg only when a configuration sequence starts, so the
  // divisor bytes stay consistent across CFG_LO/CFG_HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_q     <= 2'b00;
      cfg_done <= 1'b0;
    end else begin
      if (state_next == CFG_LO && state != CFG_LO) br_q <= br_cfg;
      if (state == CFG_HI)                         cfg_done <= 1'b1;
      else if (state == IDLE && state_next == CFG_LO) cfg_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver
// Directed bench for spart_echo_driver (50 MHz, FIFO_DEPTH=8). The bench
// plays the SPART: it returns rx_byte on every read cycle and records every
// write on the data address.
module tb_spart_echo_driver;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       clr_overflow;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       cfg_done;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] rx_byte;

  int vectors;
  int miscompares;
  logic [7:0] tx_log [32];
  int tx_count;

  spart_echo_driver #(
    .CLK_FREQ_HZ(50_000_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .br_cfg      (br_cfg),
    .iocs        (iocs),
    .iorw        (iorw),
    .rda         (rda),
    .tbr         (tbr),
    .ioaddr      (ioaddr),
    .databus     (databus),
    .cfg_done    (cfg_done),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [7:0] b,
                               input logic [1:0] br);
    rda     = r;
    tbr     = t;
    rx_byte = b;
    br_cfg  = br;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input logic [1:0] addr,
                             input logic [7:0] data);
    checkOutput({tag, "_wr"}, {30'd0, iocs, iorw}, 32'h2);
    checkOutput({tag, "_addr"}, ioaddr, addr);
    checkOutput({tag, "_data"}, databus, data);
  endtask

  // Divisor write pair, starting with the state already in CFG_LO.
  task automatic check_config(input string tag, input logic [7:0] lo,
                              input logic [7:0] hi);
    check_write({tag, "_lo"}, 2'b10, lo);
    checkOutput({tag, "_done_lo"}, cfg_done, 1'b0);
    tick();
    check_write({tag, "_hi"}, 2'b11, hi);
    checkOutput({tag, "_done_hi"}, cfg_done, 1'b0);
    tick();
    checkOutput({tag, "_done"}, cfg_done, 1'b1);
    checkOutput({tag, "_idle_cs"}, iocs, 1'b0);
  endtask

  // Receive one byte with tbr low; returns with the state back in IDLE.
  task automatic receive_byte(input logic [7:0] b);
    applyStimulus(1'b1, 1'b0, b, br_cfg);
    tick();
    checkOutput("rx_read", {29'd0, iocs, iorw, ioaddr}, 32'hC);
    rda = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input int cycles);
    tx_count = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (iocs && !iorw && tx_count < 32) begin
        tx_log[tx_count] = databus;
        tx_count++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    tx_count     = 0;
    rst          = 1'b0;
    clr_overflow = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b01);

    // Reset values and initial configuration at 9600 baud.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_iocs", iocs, 1'b0);
    checkOutput("rst_iorw", iorw, 1'b1);
    checkOutput("rst_addr", ioaddr, 2'b00);
    checkOutput("rst_done", cfg_done, 1'b0);
    checkOutput("rst_count", fifo_count, 4'd0);
    checkOutput("rst_ovf", overflow, 1'b0);
    rst = 1'b1;
    checkOutput("rst_wait_cs", iocs, 1'b0);
    tick();
    check_config("cfg9600", 8'h58, 8'h14);

    // Echo of 0x41: read, settle, idle, then write three edges after rda.
    applyStimulus(1'b1, 1'b1, 8'h41, 2'b01);
    tick();
    checkOutput("echo_read", {29'd0, iocs, iorw, ioaddr}, 32'hC);
    rda = 1'b0;
    tick();
    checkOutput("echo_settle_cs", iocs, 1'b0);
    checkOutput("echo_count1", fifo_count, 4'd1);
    tick();
    checkOutput("echo_idle_cs", iocs, 1'b0);
    tick();
    check_write("echo_tx", 2'b00, 8'h41);
    tbr = 1'b0;
    tick();
    checkOutput("echo_count0", fifo_count, 4'd0);
    tick();

    // Fill past capacity with tbr low: ninth byte is dropped.
    for (int i = 0; i < 9; i++) receive_byte(8'h30 + 8'(i));
    checkOutput("ovf_count", fifo_count, 4'd8);
    checkOutput("ovf_flag", overflow, 1'b1);
    tbr = 1'b1;
    drain(40);
    tbr = 1'b0;
    checkOutput("ovf_tx_n", tx_count, 8);
    for (int i = 0; i < 8; i++) checkOutput("ovf_tx_data", tx_log[i], 8'h30 + 8'(i));
    checkOutput("ovf_drained", fifo_count, 4'd0);
    checkOutput("ovf_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checkOutput("ovf_cleared", overflow, 1'b0);

    // Runtime reconfiguration to 38400 keeps the FIFO contents.
    receive_byte(8'hA1);
    receive_byte(8'hA2);
    receive_byte(8'hA3);
    checkOutput("recfg_count_pre", fifo_count, 4'd3);
    br_cfg = 2'b11;
    tick();
    checkOutput("recfg_count_lo", fifo_count, 4'd3);
    check_config("cfg38400", 8'h16, 8'h05);
    checkOutput("recfg_count_post", fifo_count, 4'd3);

    // rda together with a br_cfg change: configuration first, then the read.
    applyStimulus(1'b1, 1'b0, 8'hA4, 2'b00);
    tick();
    check_config("cfg4800", 8'hB0, 8'h28);
    tick();
    checkOutput("prio_read", {29'd0, iocs, iorw, ioaddr}, 32'hC);
    rda = 1'b0;
    tick();
    checkOutput("prio_count", fifo_count, 4'd4);
    tick();

    // Reset asserted in the middle of a TX write.
    tbr = 1'b1;
    for (int i = 0; i < 10 && !(iocs && !iorw); i++) tick();
    checkOutput("mid_tx_seen", {31'd0, iocs && !iorw}, 32'd1);
    checkOutput("mid_tx_data", databus, 8'hA1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_cs", iocs, 1'b0);
    checkOutput("mid_rst_count", fifo_count, 4'd0);
    checkOutput("mid_rst_done", cfg_done, 1'b0);
    tbr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rerst_wait_cs", iocs, 1'b0);
    tick();
    check_config("cfg_rerst", 8'hB0, 8'h28);

    // Carriage return handling.
    applyStimulus(1'b1, 1'b1, 8'h0D, 2'b00);
    tick();
    rda = 1'b0;
    drain(15);
    tbr = 1'b0;
`ifdef DRV_CRLF_EN
    checkOutput("cr_tx_n", tx_count, 2);
    checkOutput("cr_tx0", tx_log[0], 8'h0D);
    checkOutput("cr_tx1", tx_log[1], 8'h0A);
`else
    checkOutput("cr_tx_n", tx_count, 1);
    checkOutput("cr_tx0", tx_log[0], 8'h0D);
`endif
    checkOutput("cr_count", fifo_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
